hw_stack: RTL

- Hardware LIFO that backs the memory-mapped stack windows (`addrstack` / `userstack`) decoded by the RAM controller. Two instances are used, one per window.
- Sits directly downstream of the RAM controller's memory-map decode: consumes its select, `memwrite` and `memOut` data, and drives the stack input of the `MEMbus` read mux.
- A read of the window pops the top entry; a write pushes a new entry. Stack depth and status are exported for the status word.

---
 rtl/hw_stack_pkg.sv | 19 +
 rtl/stack_mem.sv | 28 ++
 rtl/hw_stack.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hw_stack_pkg.sv
// Shared constants for the hw_stack LIFO: default geometry, FSM encodings,
// and the status-word bit positions used by whoever packs statusOut.
package hw_stack_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;

  // Bit positions of the stack flags inside the exported status word
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UNF   = 3;
  localparam int STAT_BUSY  = 4;

  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t REFILL = 1'b1;

endpackage

// File: rtl/stack_mem.sv
// Single-port RAM holding the stack entries below the top register.
// Latency: write commits at the clock edge; read data is registered, valid one cycle later.
// Backpressure: none; one access per cycle, the caller never issues read and write together.
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-2];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/hw_stack.sv
// Memory-mapped hardware LIFO; push on write access start, pop on read access end.
// Latency: push/pop visible one cycle after the event; top refill from RAM takes one extra (busy) cycle.
// Backpressure: none; events while full/empty/busy are dropped and latched in sticky flags. Optional HW_STACK_WATERMARK_EN adds hiwater.
module hw_stack
  import hw_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sel,
  input  logic             write,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             busy,
  output logic             overflow,
  output logic             underflow,
  input  logic             clrErr
`ifdef HW_STACK_WATERMARK_EN
  ,
  output logic [CW-1:0]    hiwater
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic             sel_q;
  logic             write_q;
  state_t           state;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    cnt;
  logic             empty_r;
  logic             full_r;
  logic             ovf_r;
  logic             unf_r;

  logic             busy_w;
  logic             push_ev;
  logic             pop_ev;
  logic             do_push;
  logic             do_pop;
  logic             push_err;
  logic             pop_err;
  logic             mem_we;
  logic             mem_re;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    cnt_nxt;

  assign busy_w  = (state == REFILL);
  assign push_ev = sel & write & ~sel_q;
  // Pop commits as the read access ends so dataOut holds steady on the bus
  assign pop_ev  = sel_q & ~sel & ~write_q;

  assign do_push  = push_ev & ~busy_w & ~full_r;
  assign push_err = push_ev & (busy_w | full_r);
  assign do_pop   = pop_ev & ~busy_w & ~empty_r;
  assign pop_err  = pop_ev & (busy_w | empty_r);

  assign mem_we   = do_push & ~empty_r;
  assign mem_re   = do_pop & (cnt > CW'(1));
  assign mem_addr = do_push ? AW'(cnt - CW'(1)) : AW'(cnt - CW'(2));

  always_comb begin
    cnt_nxt = cnt;
    if (do_push) begin
      cnt_nxt = cnt + CW'(1);
    end else if (do_pop) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK   (CLK),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (top),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      state   <= IDLE;
      top     <= '0;
      cnt     <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      sel_q   <= sel;
      write_q <= write;
      state   <= mem_re ? REFILL : IDLE;
      cnt     <= cnt_nxt;
      empty_r <= (cnt_nxt == '0);
      full_r  <= (cnt_nxt == CW'(DEPTH));
      if (do_push) begin
        top <= dataIn;
      end else if (do_pop && cnt == CW'(1)) begin
        top <= '0;
      end else if (busy_w) begin
        top <= rd_data;
      end
      // A new error in the same cycle as clrErr keeps the flag set
      ovf_r <= push_err | (ovf_r & ~clrErr);
      unf_r <= pop_err  | (unf_r & ~clrErr);
    end
  end

`ifdef HW_STACK_WATERMARK_EN
  logic [CW-1:0] hiwater_r;

  always_ff @(posedge CLK) begin
    if (RST || clrErr) begin
      hiwater_r <= '0;
    end else if (cnt_nxt > hiwater_r) begin
      hiwater_r <= cnt_nxt;
    end
  end

  assign hiwater = hiwater_r;
`endif

  assign dataOut   = top;
  assign count     = cnt;
  assign empty     = empty_r;
  assign full      = full_r;
  assign busy      = busy_w;
  assign overflow  = ovf_r;
  assign underflow = unf_r;

endmodule
